// File: rtl/kripto_cok_cevrimli_birim_pkg.sv
// Shared definitions for the multi-cycle crypto/bit-manipulation unit:
// opcodes, FSM state encoding and the result used for invalid opcodes.
package kripto_paket;

   localparam logic [2:0] HMDST = 3'b000;
   localparam logic [2:0] PKG   = 3'b001;
   localparam logic [2:0] RVRS  = 3'b010;
   localparam logic [2:0] SLADD = 3'b011;
   localparam logic [2:0] CNTZ  = 3'b100;
   localparam logic [2:0] CNTP  = 3'b101;

   typedef enum logic {
      BOS = 1'b0,
      SAY = 1'b1
   } durum_t;

   // Replicated to XLEN bits wherever an invalid opcode completes.
   localparam logic GECERSIZ_SONUC = 1'b0;

endpackage

// File: rtl/kripto_cok_cevrimli_birim_dilim.sv
// Combinational chunk analyser: popcount, trailing-zero count and all-zero
// flag of one W-bit slice of the operand being scanned.
module bit_sayac_dilim #(
   parameter int W  = 8,
   parameter int CW = $clog2(W) + 1
) (
   input  logic [W-1:0]  dilim,
   output logic [CW-1:0] bir_sayisi,
   output logic [CW-1:0] sondaki_sifir,
   output logic          hepsi_sifir
);

   logic bulundu_s;

   // Scan from bit 0 upward; the first one fixes the trailing-zero count.
   always_comb begin
      bir_sayisi    = {CW{1'b0}};
      sondaki_sifir = CW'(W);
      bulundu_s     = 1'b0;
      for (int i = 0; i < W; i++) begin
         bir_sayisi = bir_sayisi + CW'(dilim[i]);
         if (!bulundu_s && dilim[i]) begin
            sondaki_sifir = CW'(i);
            bulundu_s     = 1'b1;
         end else begin
            bulundu_s = bulundu_s;
         end
      end
      hepsi_sifir = (dilim == {W{1'b0}});
   end

endmodule

// File: rtl/kripto_cok_cevrimli_birim.sv
// Multi-cycle crypto/bit-manipulation unit with accept/busy/ready handshake.
// Optional build macro: KRIPTO_CNTZ_ERKEN_BITIS_EN (cntz stops at the first set chunk).
module kripto_cok_cevrimli_birim
   import kripto_paket::*;
#(
   parameter int XLEN       = 32,
   parameter int SAYAC_ADIM = 8
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            blok_aktif_i,
   input  logic [2:0]      islem_kodu_i,
   input  logic [XLEN-1:0] yazmac_rs1_i,
   input  logic [XLEN-1:0] yazmac_rs2_i,
   output logic [XLEN-1:0] sonuc_o,
   output logic            kriptografi_hazir_o,
   output logic            mesgul_o
);

   localparam int K    = XLEN / SAYAC_ADIM;
   localparam int JW   = (K > 1) ? $clog2(K) : 1;
   localparam int CNTW = $clog2(XLEN) + 1;
   localparam int CW   = $clog2(SAYAC_ADIM) + 1;

   durum_t          durum_r;
   logic [2:0]      islem_r;
   logic [XLEN-1:0] veri_r;
   logic [JW-1:0]   j_r;
   logic [CNTW-1:0] acc_r;
   logic            bulundu_r;
   logic [XLEN-1:0] sonuc_r;
   logic            hazir_r;

   logic [CW-1:0]   pop_s;
   logic [CW-1:0]   tz_s;
   logic            sifir_s;
   logic [CNTW-1:0] acc_next_s;
   logic            bulundu_next_s;
   logic            son_dilim_s;
   logic            bitis_s;
   logic [XLEN-1:0] tek_sonuc_s;

   // veri_r is shifted down each SAY cycle, so the current chunk is always the low slice.
   bit_sayac_dilim #(
      .W  (SAYAC_ADIM),
      .CW (CW)
   ) u_dilim (
      .dilim         (veri_r[SAYAC_ADIM-1:0]),
      .bir_sayisi    (pop_s),
      .sondaki_sifir (tz_s),
      .hepsi_sifir   (sifir_s)
   );

   // Single-cycle results, computed straight from the request inputs.
   always_comb begin
      tek_sonuc_s = {XLEN{GECERSIZ_SONUC}};
      case (islem_kodu_i)
         PKG:     tek_sonuc_s = {yazmac_rs2_i[XLEN/2-1:0], yazmac_rs1_i[XLEN/2-1:0]};
         RVRS:    for (int i = 0; i < XLEN; i++) tek_sonuc_s[i] = yazmac_rs1_i[XLEN-1-i];
         SLADD:   tek_sonuc_s = {yazmac_rs1_i[XLEN-2:0], 1'b0} + yazmac_rs2_i;
         default: tek_sonuc_s = {XLEN{GECERSIZ_SONUC}};
      endcase
   end

   // Accumulator update for the chunk being processed this cycle.
   always_comb begin
      acc_next_s     = acc_r;
      bulundu_next_s = bulundu_r;
      case (islem_r)
         CNTZ: begin
            if (bulundu_r) begin
               acc_next_s = acc_r;
            end else if (sifir_s) begin
               acc_next_s = acc_r + CNTW'(SAYAC_ADIM);
            end else begin
               acc_next_s     = acc_r + CNTW'(tz_s);
               bulundu_next_s = 1'b1;
            end
         end
         default: acc_next_s = acc_r + CNTW'(pop_s);
      endcase
   end

   // Completion condition for the iterative scan.
   always_comb begin
      son_dilim_s = (j_r == JW'(K - 1));
`ifdef KRIPTO_CNTZ_ERKEN_BITIS_EN
      if ((islem_r == CNTZ) && !bulundu_r && !sifir_s) begin
         bitis_s = 1'b1;
      end else begin
         bitis_s = son_dilim_s;
      end
`else
      bitis_s = son_dilim_s;
`endif
   end

   // Control FSM with registered result, ready pulse and state.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         durum_r   <= BOS;
         islem_r   <= 3'b000;
         veri_r    <= {XLEN{1'b0}};
         j_r       <= {JW{1'b0}};
         acc_r     <= {CNTW{1'b0}};
         bulundu_r <= 1'b0;
         sonuc_r   <= {XLEN{1'b0}};
         hazir_r   <= 1'b0;
      end else begin
         case (durum_r)
            BOS: begin
               hazir_r <= 1'b0;
               if (blok_aktif_i) begin
                  case (islem_kodu_i)
                     HMDST, CNTZ, CNTP: begin
                        durum_r   <= SAY;
                        islem_r   <= islem_kodu_i;
                        veri_r    <= (islem_kodu_i == HMDST) ? (yazmac_rs1_i ^ yazmac_rs2_i)
                                                             : yazmac_rs1_i;
                        j_r       <= {JW{1'b0}};
                        acc_r     <= {CNTW{1'b0}};
                        bulundu_r <= 1'b0;
                     end
                     default: begin
                        sonuc_r <= tek_sonuc_s;
                        hazir_r <= 1'b1;
                     end
                  endcase
               end
            end
            SAY: begin
               acc_r     <= acc_next_s;
               bulundu_r <= bulundu_next_s;
               veri_r    <= veri_r >> SAYAC_ADIM;
               j_r       <= j_r + JW'(1);
               if (bitis_s) begin
                  sonuc_r <= XLEN'(acc_next_s);
                  hazir_r <= 1'b1;
                  durum_r <= BOS;
               end else begin
                  hazir_r <= 1'b0;
               end
            end
            default: begin
               durum_r <= BOS;
               hazir_r <= 1'b0;
            end
         endcase
      end
   end

   assign sonuc_o             = sonuc_r;
   assign kriptografi_hazir_o = hazir_r;
   assign mesgul_o            = (durum_r == SAY);

endmodule

// File: tb/tb_kripto_cok_cevrimli_birim.sv
// Self-checking bench for kripto_cok_cevrimli_birim (XLEN=32, SAYAC_ADIM=8).
// Expected results and latencies come from a behavioural model of the operations.
module tb_kripto_cok_cevrimli_birim;

   localparam logic [2:0] OP_HMDST = 3'b000;
   localparam logic [2:0] OP_PKG   = 3'b001;
   localparam logic [2:0] OP_RVRS  = 3'b010;
   localparam logic [2:0] OP_SLADD = 3'b011;
   localparam logic [2:0] OP_CNTZ  = 3'b100;
   localparam logic [2:0] OP_CNTP  = 3'b101;

   logic        clk;
   logic        rst;
   logic        blok;
   logic [2:0]  islem;
   logic [31:0] rs1;
   logic [31:0] rs2;
   logic [31:0] sonuc;
   logic        hazir;
   logic        mesgul;

   int checks   = 0;
   int failures = 0;

   kripto_cok_cevrimli_birim #(
      .XLEN       (32),
      .SAYAC_ADIM (8)
   ) dut (
      .clk_i               (clk),
      .rst_i               (rst),
      .blok_aktif_i        (blok),
      .islem_kodu_i        (islem),
      .yazmac_rs1_i        (rs1),
      .yazmac_rs2_i        (rs2),
      .sonuc_o             (sonuc),
      .kriptografi_hazir_o (hazir),
      .mesgul_o            (mesgul)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      logic [31:0] r;
      int tz;
      r = 32'd0;
      case (op)
         OP_HMDST: r = 32'($countones(a ^ b));
         OP_PKG:   r = {b[15:0], a[15:0]};
         OP_RVRS:  for (int i = 0; i < 32; i++) r[i] = a[31-i];
         OP_SLADD: r = (a << 1) + b;
         OP_CNTZ: begin
            tz = 32;
            for (int i = 31; i >= 0; i--) if (a[i]) tz = i;
            r = 32'(tz);
         end
         OP_CNTP:  r = 32'($countones(a));
         default:  r = 32'd0;
      endcase
      return r;
   endfunction

   // Clock edges from the accept edge until hazir is visible; also the number of busy cycles.
   function automatic int model_lat(input logic [2:0] op, input logic [31:0] a);
      int first;
      if (op == OP_HMDST || op == OP_CNTP) return 4;
      if (op != OP_CNTZ) return 0;
`ifdef KRIPTO_CNTZ_ERKEN_BITIS_EN
      if (a == 32'd0) return 4;
      first = 0;
      for (int i = 31; i >= 0; i--) if (a[i]) first = i;
      return first / 8 + 1;
`else
      first = 0;
      return 4 + first;
`endif
   endfunction

   task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
      logic [31:0] exp_val;
      int exp_lat;
      int lat;
      int busy;
      exp_val = model(op, a, b);
      exp_lat = model_lat(op, a);
      islem = op; rs1 = a; rs2 = b; blok = 1'b1;
      @(posedge clk); #1;
      blok = 1'b0;
      lat  = 0;
      busy = 0;
      while (!hazir && lat < 50) begin
         if (mesgul) busy++;
         @(posedge clk); #1;
         lat++;
      end
      checks++;
      if (hazir !== 1'b1) begin
         failures++;
         $display("FAIL %s hazir_timeout op=%0d a=%h got_lat=%0d need_lat=%0d", name, op, a, lat, exp_lat);
      end else begin
         checks++;
         if (sonuc !== exp_val) begin
            failures++;
            $display("FAIL %s result op=%0d a=%h b=%h got=%h need=%h", name, op, a, b, sonuc, exp_val);
         end
         checks++;
         if (lat !== exp_lat) begin
            failures++;
            $display("FAIL %s latency op=%0d a=%h got=%0d need=%0d", name, op, a, lat, exp_lat);
         end
         checks++;
         if (busy !== exp_lat || mesgul !== 1'b0) begin
            failures++;
            $display("FAIL %s busy op=%0d got_cycles=%0d need=%0d mesgul_at_hazir=%b", name, op, busy, exp_lat, mesgul);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; blok = 1'b0; islem = 3'b000; rs1 = 32'd0; rs2 = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (sonuc !== 32'd0 || hazir !== 1'b0 || mesgul !== 1'b0) begin
         failures++;
         $display("FAIL reset_state got sonuc=%h hazir=%b mesgul=%b need 0/0/0", sonuc, hazir, mesgul);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (sonuc !== 32'd0 || hazir !== 1'b0 || mesgul !== 1'b0) begin
         failures++;
         $display("FAIL post_reset_idle got sonuc=%h hazir=%b mesgul=%b need 0/0/0", sonuc, hazir, mesgul);
      end
   endtask

   task automatic test_directed();
      run_op("sladd_small", OP_SLADD, 32'd3, 32'd10);
      run_op("sladd_wrap", OP_SLADD, 32'h8000_0000, 32'd1);
      run_op("invalid_111", 3'b111, 32'hDEAD_BEEF, 32'h1234_5678);
      run_op("cntp_f0f0", OP_CNTP, 32'hF0F0_F0F1, 32'd0);
      run_op("hmdst_full", OP_HMDST, 32'hFFFF_0000, 32'h0000_FFFF);
      run_op("cntz_100", OP_CNTZ, 32'h0000_0100, 32'd0);
      run_op("cntz_zero", OP_CNTZ, 32'd0, 32'd0);
      run_op("cntz_msb", OP_CNTZ, 32'h8000_0000, 32'd0);
      run_op("invalid_110", 3'b110, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
   endtask

   task automatic test_back_to_back();
      islem = OP_PKG; rs1 = 32'h1234_ABCD; rs2 = 32'h5678_EF01; blok = 1'b1;
      @(posedge clk); #1;
      islem = OP_RVRS; rs1 = 32'h0000_0001; rs2 = 32'd0;
      checks++;
      if (hazir !== 1'b1 || sonuc !== 32'hEF01_ABCD) begin
         failures++;
         $display("FAIL b2b_pkg got sonuc=%h hazir=%b need EF01ABCD/1", sonuc, hazir);
      end
      @(posedge clk); #1;
      blok = 1'b0;
      checks++;
      if (hazir !== 1'b1 || sonuc !== 32'h8000_0000) begin
         failures++;
         $display("FAIL b2b_rvrs got sonuc=%h hazir=%b need 80000000/1", sonuc, hazir);
      end
      @(posedge clk); #1;
      checks++;
      if (hazir !== 1'b0 || sonuc !== 32'h8000_0000) begin
         failures++;
         $display("FAIL b2b_hold got sonuc=%h hazir=%b need 80000000/0", sonuc, hazir);
      end
   endtask

   task automatic test_busy_ignore();
      logic [31:0] prev;
      logic        changed;
      int          n;
      islem = OP_CNTP; rs1 = 32'hF0F0_F0F1; rs2 = 32'd0; blok = 1'b1;
      @(posedge clk); #1;
      prev = sonuc;
      changed = 1'b0;
      islem = OP_PKG; rs1 = 32'h1111_2222; rs2 = 32'h3333_4444;
      n = 0;
      while (!hazir && n < 20) begin
         if (sonuc !== prev) changed = 1'b1;
         @(posedge clk); #1;
         n++;
      end
      blok = 1'b0;
      checks++;
      if (changed || hazir !== 1'b1 || sonuc !== 32'd17) begin
         failures++;
         $display("FAIL busy_ignore got sonuc=%h hazir=%b early_change=%b need 00000011/1/0", sonuc, hazir, changed);
      end
      @(posedge clk); #1;
      checks++;
      if (hazir !== 1'b0 || sonuc !== 32'd17 || mesgul !== 1'b0) begin
         failures++;
         $display("FAIL busy_single_pulse got sonuc=%h hazir=%b mesgul=%b need 00000011/0/0", sonuc, hazir, mesgul);
      end
   endtask

   task automatic test_abort();
      logic saw_hazir;
      run_op("pre_abort_pkg", OP_PKG, 32'h1234_ABCD, 32'h5678_EF01);
      islem = OP_CNTP; rs1 = 32'hFFFF_FFFF; rs2 = 32'd0; blok = 1'b1;
      @(posedge clk); #1;
      blok = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if (sonuc !== 32'd0 || mesgul !== 1'b0 || hazir !== 1'b0) begin
         failures++;
         $display("FAIL abort_state got sonuc=%h hazir=%b mesgul=%b need 0/0/0", sonuc, hazir, mesgul);
      end
      saw_hazir = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         if (hazir || mesgul) saw_hazir = 1'b1;
      end
      checks++;
      if (saw_hazir !== 1'b0) begin
         failures++;
         $display("FAIL abort_no_hazir got activity=%b need 0", saw_hazir);
      end
      run_op("post_abort_cntp", OP_CNTP, 32'h0F00_00F3, 32'd0);
   endtask

   task automatic test_random();
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      for (int i = 0; i < 40; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = $urandom;
         if (op == OP_CNTZ) begin
            case ($urandom_range(0, 2))
               0:       a = 32'd1 << $urandom_range(0, 31);
               1:       a = a & (32'hFFFF_FFFF << $urandom_range(0, 31));
               default: a = (i % 5 == 0) ? 32'd0 : a;
            endcase
         end
         run_op("random", op, a, b);
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_directed();
      test_busy_ignore();
      test_abort();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/kripto_cok_cevrimli_birim.md
Name: kripto_cok_cevrimli_birim

Overview:
- Parametrised, multi-cycle successor of the single-cycle crypto/bit-manipulation unit in the execute stage.
- Executes six operations selected by a 3-bit opcode:
  - single-cycle: pkg, rvrs, sladd
  - iterative: hmdst, cntz, cntp. These scan the operand SAYAC_ADIM bits per cycle.
- Uses an accept/busy/ready handshake toward the execute controller.
- Holds the result until the next completion.

Parameters:
- XLEN, 32: operand/result width. Must be even and at least 8.
- SAYAC_ADIM, 8: bits scanned per iterative cycle. Must divide XLEN. Define K = XLEN/SAYAC_ADIM.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset. One clock; reset is synchronous and active-high.
- blok_aktif_i  in  1  request valid. Accepted only when mesgul_o=0.
- islem_kodu_i  in  3  opcode: hmdst=000, pkg=001, rvrs=010, sladd=011, cntz=100, cntp=101. Codes 110 and 111 are invalid.
- yazmac_rs1_i  in  XLEN  operand 1.
- yazmac_rs2_i  in  XLEN  operand 2.
- sonuc_o  out  XLEN  registered result. Holds its value until the next completion.
- kriptografi_hazir_o  out  1  one-cycle pulse; sonuc_o is valid in the same cycle.
- mesgul_o  out  1  high while an iterative operation is in progress.

Behaviour:
- Reset state: BOS. sonuc_o=0, kriptografi_hazir_o=0, mesgul_o=0. All internal counters and operand registers are cleared.
- States: BOS (idle), SAY (iterating).
- Accept happens at a rising edge where state is BOS and blok_aktif_i=1. Opcode and operands are latched on that edge.
- blok_aktif_i is ignored while in SAY. The request is not queued.
- Single-cycle ops and invalid opcodes:
  - The result is written on the accept edge.
  - kriptografi_hazir_o=1 for the following cycle. Latency is 1.
  - State stays BOS, so back-to-back accepts every cycle are allowed.
- pkg: {rs2[XLEN/2-1:0], rs1[XLEN/2-1:0]}.
- rvrs: bit i of the result = rs1 bit XLEN-1-i.
- sladd: (rs1<<1) + rs2, truncated mod 2^XLEN. This is the shift-1-add definition.
- Invalid opcode: result is 0 and hazir pulses as for a valid single-cycle op.
- Iterative ops, common flow:
  - The accept edge moves the state BOS->SAY and clears the accumulator and the chunk index.
  - Each SAY edge processes chunk j (bits j*SAYAC_ADIM upward, starting at j=0 = LSBs) and increments j.
  - The edge that processes chunk K-1 writes sonuc_o, returns to BOS, and produces the hazir pulse in the next cycle.
  - Latency from the accept edge to the hazir cycle is K cycles.
  - mesgul_o=1 exactly while in SAY.
  - A new request can be accepted in the cycle hazir is high.
- cntp: result = number of ones in rs1.
- hmdst: result = number of ones in (rs1 XOR rs2). The XOR is formed at latch time.
- cntz (trailing zeros, counted from bit 0):
  - An all-zero chunk adds SAYAC_ADIM to the accumulator.
  - The first chunk containing a 1 adds the trailing-zero count of that chunk and sets an internal "found" flag.
  - After the flag is set, no further additions are made.
  - rs1=0 gives XLEN.
- Result width: counts fit in log2(XLEN)+1 bits and are zero-extended to XLEN.
- rst_i mid-SAY: aborts to BOS with reset values. No hazir pulse is produced.
- blok_aktif_i low is not an abort. Once accepted, an operation always completes.

Optional Feature:
- KRIPTO_CNTZ_ERKEN_BITIS_EN defined: cntz completes on the edge that processes the first chunk containing a 1, returning to BOS.
  - Latency is (index of that chunk + 1).
  - rs1=0 still takes K cycles.
- KRIPTO_CNTZ_ERKEN_BITIS_EN undefined: cntz always takes K cycles. The result is identical in both builds.

Decomposition:
- Shared package kripto_paket:
  - opcode localparams (HMDST, PKG, RVRS, SLADD, CNTZ, CNTP)
  - state encoding (BOS, SAY)
  - the INVALID result constant 0
- One combinational sub-module, bit_sayac_dilim.
  - Input: a SAYAC_ADIM-bit chunk.
  - Outputs: popcount, trailing-zero count, and an all-zero flag.
  - Instantiated once in the iterative datapath.

Test Plan (XLEN=32, SAYAC_ADIM=8, K=4):
- pkg: rs1=0x1234ABCD, rs2=0x5678EF01 -> sonuc_o=0xEF01ABCD with hazir 1 cycle after accept. rvrs on the next cycle with rs1=0x00000001 -> 0x80000000.
- sladd: rs1=3, rs2=10 -> 16. rs1=0x80000000, rs2=1 -> 1 (wrap). Invalid opcode 111 -> 0 with hazir.
- cntp: rs1=0xF0F0F0F1 -> 17, hazir 4 cycles after accept, mesgul_o high for 4 cycles. hmdst: 0xFFFF0000 vs 0x0000FFFF -> 32.
- cntz: rs1=0x00000100 -> 8, latency 2 with the macro and 4 without. rs1=0 -> 32, latency 4 in both builds.
- Busy ignore: a pkg request during a cntp busy period is dropped. sonuc_o changes only at cntp completion, and hazir pulses once.
- rst_i asserted on the 2nd SAY cycle -> next cycle sonuc_o=0, mesgul_o=0, no hazir. A fresh cntp then returns the correct count.
